md_unit_ctrl: RTL and testbench

//  Sequencer for the multiply/divide unit that sits in the EX stage of the 5-stage pipeline.

---
 rtl/md_unit_ctrl.sv | 151 +++++++++++++++
 tb/tb_md_unit_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the EX stage: owns HI/LO,
// models fixed latency with a down-counter and stalls D-stage HI/LO users.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  state_t             w_state_n;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_n;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_hi_t;
  logic [31:0]        r_lo_t;
  logic               r_dz;
  logic               w_issue;
  logic               w_commit;
  logic               w_move;

  logic               w_bz;
  logic               w_ovf;
  logic [31:0]        w_dv;
  logic signed [63:0] w_ps;
  logic [63:0]        w_pu;
  logic signed [31:0] w_qs;
  logic signed [31:0] w_rs;
  logic [31:0]        w_qu;
  logic [31:0]        w_ru;
  logic [31:0]        w_hi_c;
  logic [31:0]        w_lo_c;

  assign w_bz  = (b == 32'd0);
  assign w_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  // Divisor forced non-zero so the divider never produces X.
  assign w_dv  = w_bz ? 32'd1 : b;

  assign w_ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_pu = {32'd0, a} * {32'd0, b};
  assign w_qs = $signed(a) / $signed(w_dv);
  assign w_rs = $signed(a) % $signed(w_dv);
  assign w_qu = a / w_dv;
  assign w_ru = a % w_dv;

  always_comb begin
    w_hi_c = 32'd0;
    w_lo_c = 32'd0;
    unique case (op)
      2'b00: begin
        w_hi_c = w_ps[63:32];
        w_lo_c = w_ps[31:0];
      end
      2'b01: begin
        w_hi_c = w_pu[63:32];
        w_lo_c = w_pu[31:0];
      end
      2'b10: begin
        w_hi_c = w_ovf ? 32'd0 : w_rs;
        w_lo_c = w_ovf ? 32'h8000_0000 : w_qs;
      end
      2'b11: begin
        w_hi_c = w_ru;
        w_lo_c = w_qu;
      end
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_issue   = 1'b0;
    w_commit  = 1'b0;
    w_move    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_issue   = 1'b1;
          w_cnt_n   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          w_state_n = S_BUSY;
        end else begin
          w_move = 1'b1;
        end
      end
      S_BUSY: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_commit  = 1'b1;
          w_cnt_n   = '0;
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_hi_t <= 32'd0;
      r_lo_t <= 32'd0;
      r_dz   <= 1'b0;
    end else begin
      if (w_issue) begin
        r_hi_t <= w_hi_c;
        r_lo_t <= w_lo_c;
        r_dz   <= op[1] & w_bz;
      end
      // Divide by zero keeps HI/LO untouched.
      if (w_commit && !r_dz) begin
        r_hi <= r_hi_t;
        r_lo <= r_lo_t;
      end
      if (w_move && mthi) r_hi <= a;
      if (w_move && mtlo) r_lo <= a;
    end
  end

  assign busy  = (r_state == S_BUSY);
  assign stall = md_use_d & (busy | start);
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed testbench for md_unit_ctrl.
// Each task drives one scenario and checks results inline.
module tb_md_unit_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        md_use_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass;
  int n_total;

  md_unit_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES(10),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .mthi(mthi),
    .mtlo(mtlo),
    .md_use_d(md_use_d),
    .busy(busy),
    .stall(stall),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op, counts busy cycles, then checks latency and HI/LO.
  task automatic run_op(input logic [1:0] t_op, input logic [31:0] t_a,
                        input logic [31:0] t_b, input int t_n,
                        input logic [31:0] e_hi, input logic [31:0] e_lo,
                        input string name);
    int cyc;
    start = 1'b1;
    op = t_op;
    a = t_a;
    b = t_b;
    tick();
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'hDEAD_BEEF;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    n_total++;
    if (cyc !== t_n)
      $display("FAIL %s_latency got %0d exp %0d", name, cyc, t_n);
    else n_pass++;
    n_total++;
    if (hi !== e_hi)
      $display("FAIL %s_hi got %h exp %h", name, hi, e_hi);
    else n_pass++;
    n_total++;
    if (lo !== e_lo)
      $display("FAIL %s_lo got %h exp %h", name, lo, e_lo);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    op = 2'b00;
    a = 32'd0;
    b = 32'd0;
    mthi = 1'b0;
    mtlo = 1'b0;
    md_use_d = 1'b1;
    tick();
    tick();
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy);
    else n_pass++;
    n_total++;
    if (hi !== 32'd0) $display("FAIL reset_hi got %h exp 0", hi);
    else n_pass++;
    n_total++;
    if (lo !== 32'd0) $display("FAIL reset_lo got %h exp 0", lo);
    else n_pass++;
    n_total++;
    if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall);
    else n_pass++;
    md_use_d = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 5,
           32'h0000_0002, 32'hFFFF_FFFA, "multu");
  endtask

  task automatic test_div();
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    run_op(2'b11, 32'd7, 32'd2, 10, 32'd1, 32'd3, "divu");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'd0, 32'h8000_0000, "div_ovf");
  endtask

  task automatic test_moves_divzero();
    mthi = 1'b1;
    a = 32'h1234;
    tick();
    mthi = 1'b0;
    mtlo = 1'b1;
    a = 32'h5678;
    tick();
    mtlo = 1'b0;
    n_total++;
    if (hi !== 32'h1234) $display("FAIL mthi got %h exp 1234", hi);
    else n_pass++;
    n_total++;
    if (lo !== 32'h5678) $display("FAIL mtlo got %h exp 5678", lo);
    else n_pass++;
    run_op(2'b10, 32'd9, 32'd0, 10, 32'h1234, 32'h5678, "div0");
    run_op(2'b11, 32'd9, 32'd0, 10, 32'h1234, 32'h5678, "divu0");
    mthi = 1'b1;
    mtlo = 1'b1;
    a = 32'hAAAA_5555;
    tick();
    mthi = 1'b0;
    mtlo = 1'b0;
    n_total++;
    if (hi !== 32'hAAAA_5555 || lo !== 32'hAAAA_5555)
      $display("FAIL mthilo got %h/%h exp aaaa5555", hi, lo);
    else n_pass++;
  endtask

  task automatic test_stall();
    int n_st;
    n_st = 0;
    md_use_d = 1'b1;
    start = 1'b1;
    op = 2'b00;
    a = 32'd2;
    b = 32'd3;
    #1;
    for (int i = 0; i < 12; i++) begin
      if (stall === 1'b1) n_st++;
      tick();
      start = 1'b0;
      #1;
    end
    n_total++;
    if (n_st !== 6) $display("FAIL stall_cycles got %0d exp 6", n_st);
    else n_pass++;
    n_total++;
    if (stall !== 1'b0) $display("FAIL stall_end got %b exp 0", stall);
    else n_pass++;
    n_total++;
    if (lo !== 32'd6 || hi !== 32'd0)
      $display("FAIL stall_result got %h/%h exp 0/6", hi, lo);
    else n_pass++;
    md_use_d = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int cyc;
    start = 1'b1;
    op = 2'b00;
    a = 32'd4;
    b = 32'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    op = 2'b11;
    a = 32'd100;
    b = 32'd7;
    mthi = 1'b1;
    mtlo = 1'b1;
    tick();
    start = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    cyc = 3;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    n_total++;
    if (cyc !== 5) $display("FAIL ignore_latency got %0d exp 5", cyc);
    else n_pass++;
    n_total++;
    if (lo !== 32'd20 || hi !== 32'd0)
      $display("FAIL ignore_result got %h/%h exp 0/14", hi, lo);
    else n_pass++;
    tick();
    n_total++;
    if (busy !== 1'b0) $display("FAIL ignore_restart got %b exp 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    start = 1'b1;
    op = 2'b11;
    a = 32'd100;
    b = 32'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_total++;
    if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy);
    else n_pass++;
    n_total++;
    if (hi !== 32'd0 || lo !== 32'd0)
      $display("FAIL midrst_hilo got %h/%h exp 0/0", hi, lo);
    else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    n_total++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0)
      $display("FAIL midrst_late got %h/%h/%b exp 0/0/0", hi, lo, busy);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_mult();
    test_div();
    test_moves_divzero();
    test_stall();
    test_busy_ignore();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
